// File: rtl/hit_pkg.sv
// rtl/hit_pkg.sv - shared state encoding, default timing constants and counter sizing
package hit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_HELD         = 3'd2,
        ST_RELEASE_WAIT = 3'd3,
        ST_LOCKOUT      = 3'd4
    } state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_LOCKOUT_CYCLES  = 5000000;

    // One counter serves both the debounce and the lockout windows.
    function automatic int cnt_width(input int debounce_cycles, input int lockout_cycles);
        int larger;
        int w;
        larger = (debounce_cycles > lockout_cycles) ? debounce_cycles : lockout_cycles;
        w      = $clog2(larger);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hit_debounce_if.sv
// rtl/hit_debounce_if.sv - raw key input and debounced hit/pressed/busy outputs
interface hit_debounce_if;

    logic key_n;
    logic hit;
    logic pressed;
    logic busy;

    modport master (
        output key_n,
        input  hit,
        input  pressed,
        input  busy
    );

    modport slave (
        input  key_n,
        output hit,
        output pressed,
        output busy
    );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, resets to 1 (idle level of an active-low key)
module sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/hit_debounce.sv
// rtl/hit_debounce.sv - debounces an active-low button into a single hit pulse with post-release lockout
module hit_debounce
    import hit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LOCKOUT_CYCLES  = DEFAULT_LOCKOUT_CYCLES
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    hit_debounce_if.slave bus
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, LOCKOUT_CYCLES);
    localparam bit HAS_LOCKOUT = (LOCKOUT_CYCLES > 0);
    localparam logic [CW-1:0] DEB_LAST  = CW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
    localparam logic [CW-1:0] LOCK_LAST = CW'(HAS_LOCKOUT ? LOCKOUT_CYCLES - 1 : 0);

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $error("hit_debounce: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic key_s;

    sync2 u_sync (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_n),
        .d_i    (bus.key_n),
        .q_o    (key_s)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic          pressed_q, pressed_d;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hit_q     <= hit_d;
            pressed_q <= pressed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!key_s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_s) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    hit_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_HELD: begin
                if (key_s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = ST_HELD;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HAS_LOCKOUT ? ST_LOCKOUT : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_LOCKOUT: begin
                // The key is deliberately ignored here; a key still down re-enters via IDLE.
                if (cnt_q == LOCK_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        pressed_d = (state_d == ST_HELD) || (state_d == ST_RELEASE_WAIT);
    end

    assign bus.hit     = hit_q;
    assign bus.pressed = pressed_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hit_debounce.sv
// tb/tb_hit_debounce.sv - scoreboard bench for hit_debounce with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8
module tb_hit_debounce;

    localparam int DEB = 4;
    localparam int LOCK = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic key_n = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   hit_count = 0;
    logic prev_hit = 1'b0;
    bit   mon_en = 1'b0;
    int   exp_q[$];

    hit_debounce_if bus_a();
    hit_debounce_if bus_b();

    assign bus_a.key_n = key_n;
    assign bus_b.key_n = key_n;

    hit_debounce #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus_a)
    );

    hit_debounce #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(0)) dut_nl (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every hit must match the next expected cycle; stray or double-cycle hits are errors.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus_a.hit === 1'b1) begin
                hit_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_hit at cycle %0d, required no hit", cyc);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (cyc !== e) begin
                        failures++;
                        $display("FAIL hit_cycle actual=%0d required=%0d", cyc, e);
                    end
                end
            end
            if (bus_a.hit === 1'b1 && prev_hit === 1'b1) begin
                checks++;
                failures++;
                $display("FAIL hit_double at cycle %0d actual=2 cycles required=1", cyc);
            end
            prev_hit = bus_a.hit;
        end
    end

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL %s missing_hits actual_pending=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({bus_a.hit, bus_a.pressed, bus_a.busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=000", {bus_a.hit, bus_a.pressed, bus_a.busy});
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_a.busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_busy actual=%b required=0", bus_a.busy);
        end
    endtask

    task automatic test_clean_press();
        int c0;
        c0 = cyc;
        exp_q.push_back(c0 + DEB + 3);
        key_n = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 20) key_n = 1'b1;
            if (i == 6 || i == 7 || i == 26 || i == 27) begin
                logic req;
                req = (i == 7 || i == 26);
                checks++;
                if (bus_a.pressed !== req) begin
                    failures++;
                    $display("FAIL clean_pressed i=%0d actual=%b required=%b", i, bus_a.pressed, req);
                end
            end
            if (i == 34 || i == 35) begin
                logic req;
                req = (i == 34);
                checks++;
                if (bus_a.busy !== req) begin
                    failures++;
                    $display("FAIL clean_lockout_busy i=%0d actual=%b required=%b", i, bus_a.busy, req);
                end
            end
            if (i == 26 || i == 27) begin
                logic req;
                req = (i == 26);
                checks++;
                if (bus_b.busy !== req) begin
                    failures++;
                    $display("FAIL no_lockout_busy i=%0d actual=%b required=%b", i, bus_b.busy, req);
                end
            end
        end
        check_drained("clean_press");
    endtask

    task automatic test_press_bounce();
        key_n = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) key_n = 1'b1;
        end
        checks++;
        if ({bus_a.pressed, bus_a.busy} !== 2'b00) begin
            failures++;
            $display("FAIL press_bounce pressed_busy actual=%b required=00", {bus_a.pressed, bus_a.busy});
        end
        check_drained("press_bounce");
    endtask

    task automatic test_release_bounce();
        int c0;
        int bad;
        c0  = cyc;
        bad = 0;
        exp_q.push_back(c0 + DEB + 3);
        key_n = 1'b0;
        for (int i = 1; i <= 42; i++) begin
            @(negedge clk);
            if (i == 12) key_n = 1'b1;
            if (i == 14) key_n = 1'b0;
            if (i == 25) key_n = 1'b1;
            if (i >= 8 && i <= 25 && bus_a.pressed !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL release_bounce pressed_drops actual=%0d required=0", bad);
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin
            failures++;
            $display("FAIL release_bounce final_busy actual=%b required=0", bus_a.busy);
        end
        check_drained("release_bounce");
    endtask

    task automatic test_lockout_repress();
        int c0;
        c0 = cyc;
        exp_q.push_back(c0 + DEB + 3);
        key_n = 1'b0;
        for (int i = 1; i <= 95; i++) begin
            @(negedge clk);
            case (i)
                12: key_n = 1'b1;
                20: key_n = 1'b0;
                23: key_n = 1'b1;
                30: begin
                    key_n = 1'b0;
                    exp_q.push_back(c0 + 30 + DEB + 3);
                end
                45: key_n = 1'b1;
                54: begin
                    // Lockout ends (IDLE entered) at edge c0+60; debounce restarts from there.
                    key_n = 1'b0;
                    exp_q.push_back(c0 + 60 + DEB + 1);
                end
                75: key_n = 1'b1;
                default: ;
            endcase
            if (i == 29) begin
                checks++;
                if ({bus_a.pressed, bus_a.busy} !== 2'b00) begin
                    failures++;
                    $display("FAIL lockout_ignore pressed_busy actual=%b required=00", {bus_a.pressed, bus_a.busy});
                end
            end
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin
            failures++;
            $display("FAIL lockout_repress final_busy actual=%b required=0", bus_a.busy);
        end
        check_drained("lockout_repress");
    endtask

    task automatic test_reset_mid_press();
        int c0;
        c0 = cyc;
        key_n = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 5) begin
                checks++;
                if (bus_a.busy !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_mid pre_busy actual=%b required=1", bus_a.busy);
                end
                reset_n = 1'b0;
                #1;
                checks++;
                if ({bus_a.hit, bus_a.pressed, bus_a.busy} !== 3'b000) begin
                    failures++;
                    $display("FAIL reset_mid async_outputs actual=%b required=000",
                             {bus_a.hit, bus_a.pressed, bus_a.busy});
                end
            end
            if (i == 7) begin
                reset_n = 1'b1;
                exp_q.push_back(c0 + 7 + DEB + 3);
            end
            if (i == 20) key_n = 1'b1;
        end
        check_drained("reset_mid_press");
    endtask

    task automatic test_back_to_back();
        int h0;
        h0 = hit_count;
        for (int p = 0; p < 5; p++) begin
            int c0;
            c0 = cyc;
            exp_q.push_back(c0 + DEB + 3);
            key_n = 1'b0;
            for (int i = 1; i <= 30; i++) begin
                @(negedge clk);
                if (i == 10) key_n = 1'b1;
            end
        end
        checks++;
        if (hit_count - h0 !== 5) begin
            failures++;
            $display("FAIL score actual=%0d required=5", hit_count - h0);
        end
        check_drained("back_to_back");
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_lockout_repress();
        test_reset_mid_press();
        test_back_to_back();
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
